// File: rtl/iq_sample_fifo.sv
// First-word-fall-through FIFO for packed DDC I/Q samples, with level/threshold
// reporting and sticky overflow with a saturating drop counter.
module iq_sample_fifo #(
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic signed [15:0]      in_i,
  input  logic signed [15:0]      in_q,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [31:0]             out_data,
  output logic [DEPTH_LOG2:0]     level,
  input  logic [DEPTH_LOG2:0]     thresh,
  output logic                    thresh_hit,
  output logic                    overflow,
  output logic [15:0]             drop_count,
  input  logic                    overflow_clr
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          thresh_hit_q, thresh_hit_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;

  logic          full_c, push_c, pop_c, drop_c;
  logic [31:0]   in_word_c;

  // Next-state: push/pop arbitration, head prefetch and overflow bookkeeping
  always_comb begin
    in_word_c    = {in_i, in_q};
    full_c       = (level_q == LW'(DEPTH));
    pop_c        = out_valid_q & out_ready;
    push_c       = enable & in_valid & (~full_c | pop_c);
    drop_c       = enable & in_valid & full_c & ~pop_c;
    level_d      = level_q + LW'(push_c) - LW'(pop_c);
    wr_ptr_d     = wr_ptr_q + PW'(push_c);
    rd_ptr_d     = rd_ptr_q + PW'(pop_c);
    out_valid_d  = (level_d != '0);
    thresh_hit_d = (thresh != '0) && (level_d >= thresh);
    out_data_d   = out_data_q;
    overflow_d   = overflow_q;
    drop_d       = drop_q;

    // Head comes straight from the input when the FIFO is left empty before this push
    if (level_d != '0) begin
      if ((level_q - LW'(pop_c)) == '0) begin
        out_data_d = in_word_c;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end

    // A drop coinciding with a clear restarts the count at one
    if (drop_c) begin
      overflow_d = 1'b1;
      if (overflow_clr) begin
        drop_d = 16'd1;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
      drop_d     = 16'd0;
    end
  end

  // Sample storage; no reset needed
  always_ff @(posedge clk) begin
    if (push_c && !reset) begin
      mem_q[wr_ptr_q] <= in_word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      thresh_hit_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      thresh_hit_q <= thresh_hit_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign level      = level_q;
  assign thresh_hit = thresh_hit_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Self-checking bench for iq_sample_fifo: queue-based reference model compared
// every cycle, plus directed literal checks on the key scenarios.
module tb_iq_sample_fifo;

  localparam int unsigned DL    = 5;
  localparam int unsigned DEPTH = 1 << DL;

  logic               clk = 1'b0;
  logic               reset, enable, in_valid, out_ready, overflow_clr;
  logic signed [15:0] in_i, in_q;
  logic               out_valid, thresh_hit, overflow;
  logic [31:0]        out_data;
  logic [DL:0]        level, thresh;
  logic [15:0]        drop_count;

  iq_sample_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .level(level), .thresh(thresh), .thresh_hit(thresh_hit),
    .overflow(overflow), .drop_count(drop_count), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_ov;
  int          m_dc;
  bit          m_th;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from the inputs seen at that edge
  task automatic model_step();
    bit want, pop, full;
    if (reset) begin
      m_q.delete();
      m_ov = 1'b0;
      m_dc = 0;
      m_th = 1'b0;
      return;
    end
    pop  = (m_q.size() != 0) && out_ready;
    want = enable && in_valid;
    full = (m_q.size() == DEPTH);
    if (pop) void'(m_q.pop_front());
    if (want && (!full || pop)) begin
      m_q.push_back({in_i, in_q});
    end else if (want) begin
      m_ov = 1'b1;
      m_dc = overflow_clr ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
    end
    if (!(want && full && !pop) && overflow_clr) begin
      m_ov = 1'b0;
      m_dc = 0;
    end
    m_th = (thresh != 0) && (m_q.size() >= int'(thresh));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] pat(input int k);
    logic [15:0] a;
    a = 16'(k);
    return {a, a ^ 16'hA5A5};
  endfunction

  task automatic drive(input logic [31:0] w);
    {in_i, in_q} = w;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
      chk("level", 32'(level), 32'(m_q.size()));
      chk("thresh_hit", 32'(thresh_hit), 32'(m_th));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("drop_count", 32'(drop_count), 32'(m_dc));
    end
  end

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    overflow_clr = 1'b0; thresh = '0; in_i = '0; in_q = '0;
    cycle();
    chk_en = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);

    // Single sample, held while not ready
    in_valid = 1'b1; in_i = 16'h1234; in_q = 16'hABCD;
    cycle();
    in_valid = 1'b0;
    chk("fwft_valid", 32'(out_valid), 32'd1);
    chk("fwft_data", out_data, 32'h1234ABCD);
    chk("fwft_level", 32'(level), 32'd1);
    repeat (10) cycle();
    chk("hold_data", out_data, 32'h1234ABCD);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("pop_level", 32'(level), 32'd0);
    chk("pop_valid", 32'(out_valid), 32'd0);

    // Overfill by two, then push-with-pop while full, then drain
    do_reset();
    for (int k = 0; k < 34; k++) begin
      in_valid = 1'b1; drive(pat(k));
      cycle();
    end
    in_valid = 1'b0;
    chk("full_level", 32'(level), 32'd32);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_drops", 32'(drop_count), 32'd2);
    overflow_clr = 1'b1;
    cycle();
    overflow_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drops", 32'(drop_count), 32'd0);
    chk("head0", out_data, pat(0));
    in_valid = 1'b1; out_ready = 1'b1; drive(pat(100));
    cycle();
    in_valid = 1'b0;
    chk("pp_level", 32'(level), 32'd32);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 32; k++) begin
      chk("drain", out_data, (k < 31) ? pat(k + 1) : pat(100));
      cycle();
    end
    out_ready = 1'b0;
    chk("drain_level", 32'(level), 32'd0);

    // Threshold flag timing
    do_reset();
    thresh = 7'(8);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; drive(pat(k + 200));
      cycle();
      chk("th_rise", 32'(thresh_hit), 32'(k == 7));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("th_level7", 32'(level), 32'd7);
    chk("th_fall", 32'(thresh_hit), 32'd0);
    thresh = '0;

    // Drop counter saturation and clear-vs-drop priority
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 32 + 65537; k++) begin
      drive(pat(k));
      cycle();
    end
    chk("sat_drops", 32'(drop_count), 32'hFFFF);
    chk("sat_ovf", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    cycle();
    chk("clrdrop_ovf", 32'(overflow), 32'd1);
    chk("clrdrop_cnt", 32'(drop_count), 32'd1);
    in_valid = 1'b0;
    cycle();
    overflow_clr = 1'b0;
    chk("clr2_ovf", 32'(overflow), 32'd0);

    // Reset in mid-operation with push and pop both asserted
    in_valid = 1'b1; out_ready = 1'b1; reset = 1'b1; drive(pat(7));
    cycle();
    reset = 1'b0;
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_data", out_data, 32'd0);
    out_ready = 1'b0; drive(pat(8));
    cycle();
    in_valid = 1'b0;
    chk("post_rst_push", out_data, pat(8));

    // Randomized traffic with phases of differing consumer speed
    for (int ph = 0; ph < 15; ph++) begin
      int rdy_pct;
      rdy_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 80 : 50);
      thresh = 6'($urandom_range(0, DEPTH));
      for (int k = 0; k < 1000; k++) begin
        enable       = ($urandom_range(0, 99) < 80);
        in_valid     = ($urandom_range(0, 99) < 55);
        out_ready    = ($urandom_range(0, 99) < rdy_pct);
        overflow_clr = ($urandom_range(0, 99) < 2);
        reset        = ($urandom_range(0, 999) == 0);
        drive($urandom);
        cycle();
      end
    end
    reset = 1'b0; in_valid = 1'b0; overflow_clr = 1'b0; out_ready = 1'b0;
    cycle();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
